// File: rtl/crc32_stream.sv
// crc32_stream: streaming CRC-32 over byte-laned beats.
// Each accepted beat is absorbed in one clock by an unrolled per-byte update.
// The finished CRC and the frame byte count are held until the consumer takes them.
// Optional feature: define CRC32_STREAM_FCS_CHECK_EN to drive out_fcs_ok from a
// good-frame residue compare; without it out_fcs_ok is tied low.
//
// Handshake: a beat moves when in_valid && in_ready on a rising clk edge, and a
// result moves when out_valid && out_ready. in_valid/in_data must not depend on
// in_ready, and out_valid never drops until the result has been consumed.
module crc32_stream #(
    parameter int          DATA_W = 8,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter bit          REFIN  = 1'b1,
    parameter bit          REFOUT = 1'b1,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_first,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_crc,
    output logic [15:0]         out_bytes,
    output logic                out_fcs_ok,
    output logic [1:0]          dbg_state
);

    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        absorb;
    logic        finish;
    logic        consume;
    logic [3:0]  n_bytes;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [31:0] crc_final;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [15:0] count_base;
    logic [16:0] count_sum;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = b[7-j];
        return r;
    endfunction

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int j = 0; j < 32; j++) r[j] = v[31-j];
        return r;
    endfunction

    // One byte through the MSB-first normal-form CRC register.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic [7:0]  bb;
        bb = REFIN ? reflect8(b) : b;
        r  = c ^ {bb, 24'h000000};
        for (int j = 0; j < 8; j++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state; a result consumed in HOLD can hand straight over to a new frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACC: if (absorb) state_next = in_last ? HOLD : ACC;
            HOLD: begin
                if (consume) begin
                    if (absorb) state_next = in_last ? HOLD : ACC;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and datapath strobes; a non-first beat outside a frame is taken and dropped.
    always_comb begin
        in_ready = (state != HOLD) | out_ready;
        accept   = in_valid & in_ready;
        absorb   = accept & (in_first | (state == ACC));
        finish   = absorb & in_last;
        consume  = (state == HOLD) & out_ready;
    end

    // Bytes to absorb: every lane mid-frame, up to the lowest cleared keep bit on the last beat.
    always_comb begin
        n_bytes = 4'(LANES);
        if (in_last) begin
            for (int l = LANES - 1; l >= 0; l--) begin
                if (!in_keep[l]) n_bytes = 4'(l);
            end
        end
    end

    // Unrolled CRC update over the enabled lanes, lane 0 first; reseeded on a first beat.
    always_comb begin
        acc_next = in_first ? INIT : acc;
        for (int l = 0; l < LANES; l++) begin
            if (l < int'(n_bytes)) acc_next = crc_byte(acc_next, in_data[8*l +: 8]);
        end
        crc_final = (REFOUT ? reflect32(acc_next) : acc_next) ^ XOROUT;
    end

    // Saturating byte count for the frame in progress.
    always_comb begin
        count_base = in_first ? 16'd0 : count;
        count_sum  = {1'b0, count_base} + 17'(n_bytes);
        count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // Accumulator, count and the held result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= INIT;
            count     <= 16'd0;
            out_valid <= 1'b0;
            out_crc   <= 32'd0;
            out_bytes <= 16'd0;
        end else begin
            if (absorb) begin
                acc   <= acc_next;
                count <= count_next;
            end
            if (finish) begin
                out_valid <= 1'b1;
                out_crc   <= crc_final;
                out_bytes <= count_next;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CRC32_STREAM_FCS_CHECK_EN
    // A frame that carries its own FCS leaves this fixed value in the finished CRC.
    localparam logic [31:0] RESIDUE = 32'h2144DF1C;

    logic fcs_ok_q;

    // Residue flag captured with the result and cleared when it is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         fcs_ok_q <= 1'b0;
        else if (finish)  fcs_ok_q <= (crc_final == RESIDUE);
        else if (consume) fcs_ok_q <= 1'b0;
    end

    assign out_fcs_ok = fcs_ok_q;
`else
    assign out_fcs_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: three crc32_stream instances (8, 32 and 64-bit beats) driven by
// directed frames and random traffic, checked every cycle against a byte-level
// reflected CRC-32 model with a per-instance expected-result queue.
`timescale 1ns/1ps
module tb_crc32_stream;

    localparam int NI = 3;

`ifdef CRC32_STREAM_FCS_CHECK_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    function automatic int wid(input int i);
        case (i)
            0:       return 8;
            1:       return 32;
            default: return 64;
        endcase
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0][63:0] in_data;
    logic [NI-1:0][7:0]  in_keep;
    logic [NI-1:0]       in_valid;
    logic [NI-1:0]       in_first;
    logic [NI-1:0]       in_last;
    logic [NI-1:0]       out_ready;
    logic [NI-1:0]       in_ready;
    logic [NI-1:0]       out_valid;
    logic [NI-1:0]       out_fcs_ok;
    logic [NI-1:0][31:0] out_crc;
    logic [NI-1:0][15:0] out_bytes;
    logic [NI-1:0][1:0]  dbg_state;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = wid(g);
        crc32_stream #(.DATA_W(W)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_data    (in_data[g][W-1:0]),
            .in_keep    (in_keep[g][W/8-1:0]),
            .in_first   (in_first[g]),
            .in_last    (in_last[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_crc    (out_crc[g]),
            .out_bytes  (out_bytes[g]),
            .out_fcs_ok (out_fcs_ok[g]),
            .dbg_state  (dbg_state[g])
        );
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Reflected (LSB-first) CRC-32 step, one byte.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [7:0] fq[$];

    function automatic logic [31:0] ref_crc_q();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fq[j]) c = crc_step(c, fq[j]);
        return c ^ 32'hFFFFFFFF;
    endfunction

    // Expected result {fcs_ok, bytes, crc} while an instance holds a result.
    logic [48:0] exp_q [NI][$];
    logic [31:0] m_run [NI];
    int          m_cnt [NI];
    bit          m_open[NI];

    // Model: follows accepted beats per instance at each clock edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                exp_q[i].delete();
                m_open[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                bit          rdy;
                int          lanes;
                int          k;
                logic [31:0] res;
                bit          fcs;
                rdy = (exp_q[i].size() == 0) || out_ready[i];
                if (exp_q[i].size() > 0 && out_ready[i]) void'(exp_q[i].pop_front());
                if (in_valid[i] && rdy && (in_first[i] || m_open[i])) begin
                    if (in_first[i]) begin
                        m_run[i]  = 32'hFFFFFFFF;
                        m_cnt[i]  = 0;
                        m_open[i] = 1'b1;
                    end
                    lanes = wid(i) / 8;
                    k = lanes;
                    if (in_last[i]) begin
                        k = 0;
                        while (k < lanes && in_keep[i][k]) k++;
                    end
                    for (int l = 0; l < k; l++) begin
                        m_run[i] = crc_step(m_run[i], in_data[i][8*l +: 8]);
                        if (m_cnt[i] < 65535) m_cnt[i]++;
                    end
                    if (in_last[i]) begin
                        res = m_run[i] ^ 32'hFFFFFFFF;
                        fcs = FCS_ON && (res == 32'h2144DF1C);
                        exp_q[i].push_back({fcs, 16'(m_cnt[i]), res});
                        m_open[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("in_ready", i, in_ready[i], (exp_q[i].size() == 0) || out_ready[i]);
            chk("out_valid", i, out_valid[i], exp_q[i].size() > 0);
            if (exp_q[i].size() > 0) begin
                chk("out_crc", i, out_crc[i], exp_q[i][0][31:0]);
                chk("out_bytes", i, out_bytes[i], exp_q[i][0][47:32]);
                chk("out_fcs_ok", i, out_fcs_ok[i], exp_q[i][0][48]);
            end
        end
    end

    // ---------------- drivers ----------------
    bit rand_mode  = 1'b0;
    bit rand_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            for (int i = 0; i < NI; i++) out_ready[i] = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the handshake completes.
    task automatic send_beat(input int i, input logic [63:0] d, input logic [7:0] k,
                             input bit f, input bit l);
        bit rd;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_keep[i]  = k;
        in_first[i] = f;
        in_last[i]  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            rd = in_ready[i];
            @(posedge clk);
            #1;
            if (rd) begin
                in_valid[i] = 1'b0;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_beat[%0d]: in_ready stayed 0 for 200 cycles, expected 1", i);
        in_valid[i] = 1'b0;
    endtask

    // Send the bytes in fq as a frame; with_last=0 leaves it open.
    task automatic send_frame(input int i, input bit with_last);
        int lanes, n, pos, rem, beats;
        logic [63:0] d;
        logic [7:0]  k;
        bit          is_last;
        lanes = wid(i) / 8;
        n     = fq.size();
        pos   = 0;
        beats = (n == 0) ? 1 : (n + lanes - 1) / lanes;
        for (int b = 0; b < beats; b++) begin
            d   = {$urandom, $urandom};
            rem = (n - pos < lanes) ? n - pos : lanes;
            for (int l = 0; l < rem; l++) d[8*l +: 8] = fq[pos+l];
            pos += rem;
            is_last = with_last && (b == beats - 1);
            k = rand_mode ? 8'($urandom) : 8'hFF;
            if (is_last) begin
                if (!rand_mode) k = 8'h00;
                for (int l = 0; l < rem; l++) k[l] = 1'b1;
                if (rem < lanes) k[rem] = 1'b0;
            end
            send_beat(i, d, k, b == 0, is_last);
            if (rand_mode && $urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic load_digits();
        fq.delete();
        for (int j = 0; j < 9; j++) fq.push_back(8'(49 + j));
    endtask

    // Result must be present one cycle after the last beat was accepted.
    task automatic expect_result(input int i, input logic [31:0] crc, input logic [15:0] nb, input bit fcs);
        @(negedge clk);
        chk("lat1_valid", i, out_valid[i], 1'b1);
        chk("lit_crc", i, out_crc[i], crc);
        chk("lit_bytes", i, out_bytes[i], nb);
        chk("lit_fcs_ok", i, out_fcs_ok[i], fcs);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b0;
        in_valid  = '0;
        in_first  = '0;
        in_last   = '0;
        in_data   = '0;
        in_keep   = '0;
        out_ready = '1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", i, out_valid[i], 1'b0);
            chk("rst_in_ready", i, in_ready[i], 1'b1);
            chk("rst_out_crc", i, out_crc[i], 32'h0);
            chk("rst_out_bytes", i, out_bytes[i], 16'h0);
            chk("rst_fcs_ok", i, out_fcs_ok[i], 1'b0);
            chk("rst_state", i, dbg_state[i], 2'd0);
        end
        rst = 1'b1;
        tick();

        // Model pins.
        load_digits();
        chk("model_check", 0, ref_crc_q(), 32'hCBF43926);
        fq.push_back(8'h26); fq.push_back(8'h39); fq.push_back(8'hF4); fq.push_back(8'hCB);
        chk("model_residue", 0, ref_crc_q(), 32'h2144DF1C);

        // Byte-wide check value.
        load_digits();
        send_frame(0, 1'b1);
        expect_result(0, 32'hCBF43926, 16'd9, 1'b0);

        // Non-first beat in IDLE is dropped.
        send_beat(0, 64'hA5, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        chk("idle_drop_valid", 0, out_valid[0], 1'b0);
        chk("idle_drop_state", 0, dbg_state[0], 2'd0);
        tick();

        // Abort and restart.
        fq.delete(); fq.push_back(8'h61); fq.push_back(8'h62);
        send_frame(0, 1'b0);
        load_digits();
        send_frame(0, 1'b1);
        expect_result(0, 32'hCBF43926, 16'd9, 1'b0);

        // 32-bit beats, last keep 4'b0001.
        load_digits();
        send_frame(1, 1'b1);
        expect_result(1, 32'hCBF43926, 16'd9, 1'b0);

        // Empty last beat still finishes the frame.
        send_beat(1, 64'h12345678, 8'h00, 1'b1, 1'b1);
        expect_result(1, 32'h0, 16'd0, 1'b0);

        // 64-bit beats with appended FCS.
        load_digits();
        fq.push_back(8'h26); fq.push_back(8'h39); fq.push_back(8'hF4); fq.push_back(8'hCB);
        send_frame(2, 1'b1);
        expect_result(2, 32'h2144DF1C, 16'd13, FCS_ON);

        // Backpressure on the result, then consume and start in the same cycle.
        out_ready[1] = 1'b0;
        load_digits();
        send_frame(1, 1'b1);
        expect_result(1, 32'hCBF43926, 16'd9, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 1, in_ready[1], 1'b0);
            chk("bp_crc", 1, out_crc[1], 32'hCBF43926);
            chk("bp_bytes", 1, out_bytes[1], 16'd9);
            tick();
        end
        out_ready[1] = 1'b1;
        send_beat(1, 64'h34333231, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        chk("handover_valid", 1, out_valid[1], 1'b0);
        chk("handover_state", 1, dbg_state[1], 2'd1);
        tick();
        send_beat(1, 64'h38373635, 8'h0F, 1'b0, 1'b0);
        send_beat(1, 64'hDEADBE39, 8'h01, 1'b0, 1'b1);
        expect_result(1, 32'hCBF43926, 16'd9, 1'b0);

        // Reset in HOLD (instance 0) and mid-frame (instance 2).
        out_ready[0] = 1'b0;
        load_digits();
        send_frame(0, 1'b1);
        fq.delete(); fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
        send_frame(2, 1'b0);
        chk("pre_rst_hold", 0, dbg_state[0], 2'd2);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("arst_out_valid", i, out_valid[i], 1'b0);
            chk("arst_in_ready", i, in_ready[i], 1'b1);
            chk("arst_out_crc", i, out_crc[i], 32'h0);
            chk("arst_out_bytes", i, out_bytes[i], 16'h0);
        end
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_state", 0, dbg_state[0], 2'd0);
        chk("post_rst_bytes", 0, out_bytes[0], 16'h0);
        out_ready[0] = 1'b1;
        send_beat(2, 64'h0, 8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_drop", 2, out_valid[2], 1'b0);
        tick();

        // Random traffic.
        rand_mode  = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < NI; i++) begin
            for (int f = 0; f < 30; f++) begin
                int len;
                int kind;
                len = $urandom_range(0, 3 * (wid(i) / 8) + 3);
                fq.delete();
                for (int j = 0; j < len; j++) fq.push_back(8'($urandom));
                kind = $urandom_range(0, 7);
                if (kind == 0) begin
                    send_frame(i, 1'b0);
                end else if (kind == 1) begin
                    send_beat(i, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
                    send_frame(i, 1'b1);
                end else begin
                    send_frame(i, 1'b1);
                end
            end
        end
        rand_ready = 1'b0;
        rand_mode  = 1'b0;
        tick();
        out_ready = '1;
        repeat (4) tick();

        // Byte count saturation: 8200 full 8-byte beats.
        send_beat(2, {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
        for (int b = 1; b < 8199; b++) send_beat(2, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
        send_beat(2, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        chk("sat_valid", 2, out_valid[2], 1'b1);
        chk("sat_bytes", 2, out_bytes[2], 16'hFFFF);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
